// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the GPR issue/writeback sequencer.
// Register-file geometry, writeback latency classes and reservation entry layout.
// Helper maps a latency class to its reservation slot in the writeback pipe.
package gpr_ctrl_pkg;

  localparam int NREG = 8;
  localparam int RW   = $clog2(NREG);

  // Latency class of an op: selects which writeback slot it reserves
  typedef enum logic {
    LAT_ALU = 1'b0,
    LAT_MUL = 1'b1
  } lat_class_e;

  // One writeback reservation
  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   dst;
    lat_class_e      cls;
  } wb_ent_t;

  // Slot index (1-based) at which an op of the given class is loaded
  function automatic int wb_slot(input lat_class_e cls, input int alu_lat, input int mul_lat);
    return (cls == LAT_MUL) ? (mul_lat + 1) : (alu_lat + 1);
  endfunction

endpackage

// File: rtl/gpr_wb_pipe.sv
// Writeback reservation shift register, D = MUL_LAT+1 slots, slot 1 is the write slot.
// Latency: an entry loaded at slot L reaches slot 1 after L-1 edges, written on the L-th.
// No backpressure: the issuer guarantees the load slot is free after the shift.
module gpr_wb_pipe
  import gpr_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_load,
  input  logic [RW-1:0]        i_dst,
  input  logic                 i_is_mul,
  output logic                 o_head_vld,
  output logic [RW-1:0]        o_head_dst,
  output logic                 o_head_mul,
  output logic [MUL_LAT+1:1]   o_vld
);

  localparam int D = MUL_LAT + 1;

  wb_ent_t    r_p [1:D];
  wb_ent_t    w_ent;
  lat_class_e w_cls;

  assign w_cls = lat_class_e'(i_is_mul);
  assign w_ent = '{valid: 1'b1, dst: i_dst, cls: w_cls};

  // Shift toward slot 1 every edge; a new reservation overwrites its slot after the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '{default: '0};
    end else if (i_flush) begin
      r_p <= '{default: '0};
    end else begin
      for (int k = 1; k < D; k++) r_p[k] <= r_p[k+1];
      r_p[D] <= '0;
      if (i_load) r_p[wb_slot(w_cls, ALU_LAT, MUL_LAT)] <= w_ent;
    end
  end

  // Per-slot valid bits for the write-port collision check and busy
  always_comb begin
    o_vld = '0;
    for (int k = 1; k <= D; k++) o_vld[k] = r_p[k].valid;
  end

  assign o_head_vld = r_p[1].valid;
  assign o_head_dst = r_p[1].dst;
  assign o_head_mul = (r_p[1].cls == LAT_MUL);

endmodule

// File: rtl/gpr_issue_ctrl.sv
// Issue/writeback sequencer for the 8x8 GPR file: scoreboard, hazard stall, stall counter.
// Latency: read enables combinational on accept; write ALU_LAT+1 or MUL_LAT+1 edges after accept.
// Backpressure: iss_ready drops on flush, RAW, WAW or write-port collision; counted in stall_cnt.
module gpr_issue_ctrl
  import gpr_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int CW      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RW-1:0]   iss_src_a,
  input  logic [RW-1:0]   iss_src_b,
  input  logic [RW-1:0]   iss_dst,
  input  logic            iss_wr,
  input  logic            iss_is_mul,
  input  logic            flush,
  output logic            rf_read_en,
  output logic [RW-1:0]   rf_a_num,
  output logic [RW-1:0]   rf_b_num,
  output logic            rf_write_en,
  output logic [RW-1:0]   rf_c_num,
  output logic            wb_is_mul,
  output logic            busy,
  output logic [CW-1:0]   stall_cnt
);

  localparam int D  = MUL_LAT + 1;
  localparam int LA = ALU_LAT + 1;

  logic [NREG-1:0] r_pend;
  logic [CW-1:0]   r_stall_cnt;

  logic            w_raw, w_waw, w_port, w_acc;
  logic            w_head_vld, w_head_mul;
  logic [RW-1:0]   w_head_dst;
  logic [D:1]      w_slot_vld;
  logic [NREG-1:0] w_set, w_clr;

  gpr_wb_pipe #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_load     (w_acc && iss_wr),
    .i_dst      (iss_dst),
    .i_is_mul   (iss_is_mul),
    .o_head_vld (w_head_vld),
    .o_head_dst (w_head_dst),
    .o_head_mul (w_head_mul),
    .o_vld      (w_slot_vld)
  );

  // No same-edge bypass: a register being written this edge still blocks readers
  assign w_raw  = r_pend[iss_src_a] | r_pend[iss_src_b];
  assign w_waw  = iss_wr & r_pend[iss_dst];
  // An ALU op would land in the slot the entry above it shifts into
  assign w_port = iss_wr & ~iss_is_mul & w_slot_vld[LA+1];

  assign iss_ready = ~flush & ~w_raw & ~w_waw & ~w_port;
  assign w_acc     = iss_valid & iss_ready;

  assign w_set = (w_acc && iss_wr) ? (NREG'(1) << iss_dst)    : '0;
  assign w_clr = w_head_vld        ? (NREG'(1) << w_head_dst) : '0;

  // Scoreboard: mark destination on accept, release at its write edge, drop all on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_pend <= '0;
    else if (flush) r_pend <= '0;
    else            r_pend <= (r_pend & ~w_clr) | w_set;
  end

  // Saturating count of offered-but-refused cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cnt <= '0;
    else if (iss_valid && !iss_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign rf_read_en  = w_acc;
  assign rf_a_num    = iss_src_a;
  assign rf_b_num    = iss_src_b;
  assign rf_write_en = w_head_vld & ~flush;
  assign rf_c_num    = w_head_dst;
  assign wb_is_mul   = w_head_mul;
  assign busy        = (|r_pend) | (|w_slot_vld);
  assign stall_cnt   = r_stall_cnt;

endmodule
